pc_redirect_unit: RTL and testbench
===================================

Name: pc_redirect_unit

Overview:
- Program-counter register and next-PC selector at the front of the IF stage.
- Consumes the branch target produced by the EX-stage branch adder, together with the EX branch-taken decision.
- Sequences the PC through normal +4 fetch, pipeline-freeze stalls and taken-branch redirects.
- Generates the one-cycle flush pulses that squash the wrong-path instructions in IF/ID and ID/EX.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, sequential fetch increment in bytes.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hazard-unit freeze: PC holds, no redirect is applied.
- branch_taken  input  1  EX stage reports a taken branch or jump this cycle.
- branch_address  input  32  EX-stage branch target (PC_address + imm).
- pc_out  output  32  current fetch address (registered).
- pc_plus4  output  32  pc_out + PC_STEP (combinational, modulo 2^32).
- flush_if_id  output  1  squash the IF/ID register this cycle.
- flush_id_ex  output  1  squash the ID/EX register this cycle.
- redirect_pending  output  1  a taken branch is held while stalled (registered).

Behaviour:
- Reset (async, rst=1): pc_out=RESET_PC, pending_target=0, redirect_pending=0. flush_if_id and flush_id_ex are 0 while rst=1.
- Deassertion of rst takes effect at the next rising edge. The first fetch address is RESET_PC.
- Internal state: pending_target[31:0] and the redirect_pending flag.
- The effective redirect this cycle is either of:
  - branch_taken=1, target branch_address.
  - redirect_pending=1 with branch_taken=0, target pending_target.
  - branch_taken=1 overrides a pending target (newest wins).
- Next-state rules at the rising edge, in priority order:
  1. stall=1 and effective redirect: pending_target<=target, redirect_pending<=1, pc_out holds.
  2. stall=1, no redirect: all state holds.
  3. stall=0 and effective redirect: pc_out<=target, redirect_pending<=0.
  4. stall=0, no redirect: pc_out<=pc_out+PC_STEP.
- Flush outputs:
  - flush_if_id = flush_id_ex = ~stall & (branch_taken | redirect_pending).
  - Combinational, asserted in the same cycle the redirect is applied, for exactly one cycle per applied redirect.
  - Never asserted while stall=1.
- Latency: a taken branch seen with stall=0 makes the target appear on pc_out after one edge. When the branch arrives under stall, the target appears one edge after stall falls.
- Arithmetic: 32-bit unsigned, wrap-around. 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
- Alignment: branch_address is used as given. Bits [1:0] are not masked (see optional feature).
- Reset mid-stall or with a pending redirect discards the pending target. No flush occurs after reset release.
- pc_plus4 always tracks pc_out, including during stall and reset.

Optional Feature:
- Macro PC_MISALIGN_TRAP_EN.
- When defined:
  - Adds output misalign_fault (1 bit, registered, reset 0).
  - When a redirect is applied (rule 3) with target[1:0]!=2'b00, pc_out still loads the target and misalign_fault<=1 for one cycle.
  - misalign_fault is 0 otherwise.
- When undefined: the port does not exist and targets are never checked.

Test Plan:
- Reset release, stall=0, branch_taken=0 for 4 cycles -> pc_out 0,4,8,12,16; flushes stay 0; pc_plus4 = pc_out+4.
- At pc_out=16, branch_taken=1, branch_address=24, stall=0 -> flush_if_id=flush_id_ex=1 that cycle; next pc_out=24, then 28.
- stall=1 for 3 cycles, no branch -> pc_out frozen, pc_plus4 frozen, flushes 0. Release stall -> +4 resumes.
- stall=1 with branch_taken=1, branch_address=32'h100 for one cycle, stall held 2 more cycles:
  - redirect_pending=1 and flushes 0 throughout the stall.
  - First cycle with stall=0: flushes=1, next pc_out=32'h100, redirect_pending=0.
- rst asserted mid-stall with redirect_pending=1 -> pc_out=RESET_PC immediately (async), redirect_pending=0; no flush after release.
- pc_out=32'hFFFF_FFFC, stall=0 -> next pc_out=0. With PC_MISALIGN_TRAP_EN, a redirect to 32'h0000_0102 -> pc_out=0x102, misalign_fault=1 for exactly one cycle.

Source files
------------

// File: rtl/pc_redirect_unit.sv
// rtl/pc_redirect_unit.sv - IF-stage program counter with stall hold and branch redirect
//
// Purpose:
//   Holds the fetch PC and selects its next value. The PC advances by PC_STEP,
//   freezes under stall, or is redirected to a taken-branch target from EX.
//   A redirect that arrives while stalled is parked in pending_target and
//   applied on the first unstalled cycle. The flush pulses squash the
//   wrong-path instructions in IF/ID and ID/EX in the cycle the redirect is
//   applied.
//
// Optional feature:
//   PC_MISALIGN_TRAP_EN - adds registered output misalign_fault, raised for one
//   cycle after a redirect to a target whose bits [1:0] are not zero.
//
// Ports:
//   clk              in   rising-edge clock
//   rst              in   asynchronous active-high reset
//   stall            in   hazard freeze: PC holds, no redirect is applied
//   branch_taken     in   EX reports a taken branch/jump this cycle
//   branch_address   in   EX branch target (32 bits)
//   pc_out           out  current fetch address (registered)
//   pc_plus4         out  pc_out + PC_STEP (combinational, wraps)
//   flush_if_id      out  squash IF/ID this cycle
//   flush_id_ex      out  squash ID/EX this cycle
//   redirect_pending out  a taken branch is parked while stalled (registered)
//   misalign_fault   out  (PC_MISALIGN_TRAP_EN only) misaligned redirect seen

module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_address,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        redirect_pending
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic        misalign_fault
`endif
);

  logic [31:0] pending_target;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        redirect_apply;

  logic [31:0] pc_next;
  logic [31:0] pending_target_next;
  logic        redirect_pending_next;

  // A fresh branch from EX is newer than anything parked, so it wins.
  assign redirect_valid  = branch_taken | redirect_pending;
  assign redirect_target = branch_taken ? branch_address : pending_target;
  assign redirect_apply  = ~stall & redirect_valid;

  assign pc_plus4 = pc_out + 32'(PC_STEP);

  // Gated by rst so a branch_taken seen during reset cannot squash anything.
  assign flush_if_id = redirect_apply & ~rst;
  assign flush_id_ex = redirect_apply & ~rst;

  always_comb begin
    pc_next               = pc_out;
    pending_target_next   = pending_target;
    redirect_pending_next = redirect_pending;
    if (stall) begin
      if (redirect_valid) begin
        pending_target_next   = redirect_target;
        redirect_pending_next = 1'b1;
      end
    end else if (redirect_valid) begin
      pc_next               = redirect_target;
      redirect_pending_next = 1'b0;
    end else begin
      pc_next = pc_plus4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_out           <= RESET_PC;
      pending_target   <= 32'h0000_0000;
      redirect_pending <= 1'b0;
    end else begin
      pc_out           <= pc_next;
      pending_target   <= pending_target_next;
      redirect_pending <= redirect_pending_next;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  // Target is still loaded; the fault only reports it, for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_fault <= 1'b0;
    end else begin
      misalign_fault <= redirect_apply & (redirect_target[1:0] != 2'b00);
    end
  end
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb/tb_pc_redirect_unit.sv - self-checking bench for pc_redirect_unit

module tb_pc_redirect_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        redirect_pending;
`ifdef PC_MISALIGN_TRAP_EN
  logic        misalign_fault;
`endif

  pc_redirect_unit #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .branch_taken     (branch_taken),
    .branch_address   (branch_address),
    .pc_out           (pc_out),
    .pc_plus4         (pc_plus4),
    .flush_if_id      (flush_if_id),
    .flush_id_ex      (flush_id_ex),
    .redirect_pending (redirect_pending)
`ifdef PC_MISALIGN_TRAP_EN
    ,
    .misalign_fault   (misalign_fault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic        b;
    logic [31:0] a;
    logic [31:0] pc;
    logic        f;
    logic        p;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        f;
    logic        p;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic void add(input logic s, input logic b, input logic [31:0] a,
                              input logic [31:0] pc, input logic f, input logic p);
    vec_t v;
    v.s = s; v.b = b; v.a = a; v.pc = pc; v.f = f; v.p = p;
    vecs.push_back(v);
  endfunction

  // Drive one vector (called just after a falling edge), then sample mid-low-phase.
  task automatic drive_and_check(input vec_t v, input int idx);
    exp_t e;
    stall          = v.s;
    branch_taken   = v.b;
    branch_address = v.a;
    e.pc = v.pc; e.f = v.f; e.p = v.p;
    sb.push_back(e);
    #2;
    e = sb.pop_front();
    chk($sformatf("v%0d pc_out", idx), pc_out, e.pc);
    chk($sformatf("v%0d pc_plus4", idx), pc_plus4, e.pc + 32'd4);
    chk($sformatf("v%0d flush_if_id", idx), 32'(flush_if_id), 32'(e.f));
    chk($sformatf("v%0d flush_id_ex", idx), 32'(flush_id_ex), 32'(e.f));
    chk($sformatf("v%0d pending", idx), 32'(redirect_pending), 32'(e.p));
  endtask

  initial begin
    //  stall br  address        exp pc         flush pend
    add(0, 0, 32'h0,          32'h0000_0000, 0, 0);
    add(0, 0, 32'h0,          32'h0000_0004, 0, 0);
    add(0, 0, 32'h0,          32'h0000_0008, 0, 0);
    add(0, 0, 32'h0,          32'h0000_000C, 0, 0);
    add(0, 1, 32'd24,         32'h0000_0010, 1, 0);
    add(0, 0, 32'h0,          32'h0000_0018, 0, 0);
    add(0, 0, 32'h0,          32'h0000_001C, 0, 0);
    add(1, 0, 32'h0,          32'h0000_0020, 0, 0);
    add(1, 0, 32'h0,          32'h0000_0020, 0, 0);
    add(1, 0, 32'h0,          32'h0000_0020, 0, 0);
    add(0, 0, 32'h0,          32'h0000_0020, 0, 0);
    add(0, 0, 32'h0,          32'h0000_0024, 0, 0);
    add(1, 1, 32'h100,        32'h0000_0028, 0, 0);
    add(1, 0, 32'h0,          32'h0000_0028, 0, 1);
    add(1, 0, 32'h0,          32'h0000_0028, 0, 1);
    add(0, 0, 32'h0,          32'h0000_0028, 1, 1);
    add(0, 0, 32'h0,          32'h0000_0100, 0, 0);
    add(1, 1, 32'h200,        32'h0000_0104, 0, 0);
    add(0, 1, 32'h300,        32'h0000_0104, 1, 1);
    add(0, 0, 32'h0,          32'h0000_0300, 0, 0);
    add(0, 1, 32'hFFFF_FFFC,  32'h0000_0304, 1, 0);
    add(0, 0, 32'h0,          32'hFFFF_FFFC, 0, 0);
    add(0, 0, 32'h0,          32'h0000_0000, 0, 0);

    rst = 1'b1; stall = 1'b0; branch_taken = 1'b1; branch_address = 32'h55;
    @(negedge clk); #2;
    chk("reset pc_out", pc_out, 32'h0);
    chk("reset pc_plus4", pc_plus4, 32'h4);
    chk("reset pending", 32'(redirect_pending), 32'h0);
    chk("reset flush_if_id", 32'(flush_if_id), 32'h0);
    chk("reset flush_id_ex", 32'(flush_id_ex), 32'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      if (i == 0) rst = 1'b0;
      drive_and_check(vecs[i], i);
    end

    // Reset asserted mid-stall while a redirect is parked (pc_out is 4 here).
    @(negedge clk);
    stall = 1'b1; branch_taken = 1'b1; branch_address = 32'h500;
    @(negedge clk);
    branch_taken = 1'b0;
    #2;
    chk("park pending", 32'(redirect_pending), 32'h1);
    chk("park pc_out", pc_out, 32'h4);
    chk("park flush", 32'(flush_if_id), 32'h0);
    rst = 1'b1;
    #1;
    chk("async rst pc_out", pc_out, 32'h0);
    chk("async rst pending", 32'(redirect_pending), 32'h0);
    stall = 1'b0; branch_taken = 1'b1;
    #1;
    chk("rst flush_if_id", 32'(flush_if_id), 32'h0);
    chk("rst flush_id_ex", 32'(flush_id_ex), 32'h0);
    @(negedge clk);
    rst = 1'b0; branch_taken = 1'b0; stall = 1'b0;
    #2;
    chk("post-rst pc_out", pc_out, 32'h0);
    chk("post-rst flush", 32'(flush_if_id | flush_id_ex), 32'h0);
    @(negedge clk); #2;
    chk("post-rst pc_out+1", pc_out, 32'h4);
    chk("post-rst no flush", 32'(flush_if_id | flush_id_ex), 32'h0);
    chk("post-rst pending", 32'(redirect_pending), 32'h0);

`ifdef PC_MISALIGN_TRAP_EN
    @(negedge clk);
    branch_taken = 1'b1; branch_address = 32'h0000_0102;
    #2;
    chk("mis before", 32'(misalign_fault), 32'h0);
    @(negedge clk);
    branch_taken = 1'b0;
    #2;
    chk("mis pc_out", pc_out, 32'h0000_0102);
    chk("mis fault", 32'(misalign_fault), 32'h1);
    @(negedge clk); #2;
    chk("mis one-shot", 32'(misalign_fault), 32'h0);
    chk("mis pc next", pc_out, 32'h0000_0106);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
